// File: rtl/video_pattern_gen.sv
// video_pattern_gen: parametrised video timing and test-pattern generator.
// Ports: clk, rst (sync, active-high); pattern_sel (0 bars, 1 ramp, 2 grid, 3 solid);
//        solid_r/g/b (mode-3 colour); hs/vs (polarity HS_POL/VS_POL); de;
//        rgb_r/g/b (zero outside de); frame_start (pulse on pixel 0,0).
module video_pattern_gen #(
    parameter int H_ACTIVE   = 1920,
    parameter int H_FP       = 88,
    parameter int H_SYNC     = 44,
    parameter int H_BP       = 148,
    parameter int V_ACTIVE   = 1080,
    parameter int V_FP       = 4,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 36,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int DW         = 8,
    parameter int CNT_W      = 12,
    parameter int RAMP_SHIFT = 3,
    parameter int GRID_LOG2  = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pattern_sel,
    input  logic [DW-1:0] solid_r,
    input  logic [DW-1:0] solid_g,
    input  logic [DW-1:0] solid_b,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [DW-1:0] rgb_r,
    output logic [DW-1:0] rgb_g,
    output logic [DW-1:0] rgb_b,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0]    BAR_LAST = BW'(BAR_W - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HA       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HA_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VA_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_S     = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_S     = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt, v_cnt, ramp_x;
    logic [BW-1:0]    bar_cnt;
    logic [2:0]       bar_idx;
    logic [1:0]       mode;
    logic [DW-1:0]    sol_r, sol_g, sol_b, pix_r, pix_g, pix_b, ramp;
    logic             h_end, v_end, act, hs_act, vs_act, grid_on;

    // Bar colours follow the index bits: r = ~idx[1], g = ~idx[2], b = ~idx[0]
    // gives white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        h_end   = h_cnt == H_LAST;
        v_end   = v_cnt == V_LAST;
        act     = (h_cnt < HA) && (v_cnt < VA);
        hs_act  = (h_cnt >= HS_S) && (h_cnt < HS_E);
        vs_act  = (v_cnt >= VS_S) && (v_cnt < VS_E);
        grid_on = (h_cnt[GRID_LOG2-1:0] == '0) || (v_cnt[GRID_LOG2-1:0] == '0) ||
                  (h_cnt == HA_LAST) || (v_cnt == VA_LAST);
        ramp_x  = h_cnt >> RAMP_SHIFT;
        ramp    = DW'(ramp_x);
        pix_r   = mode == 2'd0 ? {DW{~bar_idx[1]}} : mode == 2'd1 ? ramp : mode == 2'd2 ? {DW{grid_on}} : sol_r;
        pix_g   = mode == 2'd0 ? {DW{~bar_idx[2]}} : mode == 2'd1 ? ramp : mode == 2'd2 ? {DW{grid_on}} : sol_g;
        pix_b   = mode == 2'd0 ? {DW{~bar_idx[0]}} : mode == 2'd1 ? ramp : mode == 2'd2 ? {DW{grid_on}} : sol_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            mode        <= '0;
            sol_r       <= '0;
            sol_g       <= '0;
            sol_b       <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            // bar_cnt/bar_idx track h_cnt so bar boundaries need no divider
            if (h_end) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
            // last cycle of the frame: new settings take effect from pixel (0,0)
            if (h_end && v_end) begin
                mode  <= pattern_sel;
                sol_r <= solid_r;
                sol_g <= solid_g;
                sol_b <= solid_b;
            end
            de          <= act;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            hs          <= hs_act ? HS_POL : ~HS_POL;
            vs          <= vs_act ? VS_POL : ~VS_POL;
            rgb_r       <= act ? pix_r : '0;
            rgb_g       <= act ? pix_g : '0;
            rgb_b       <= act ? pix_b : '0;
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks of raster timing, patterns, mode latch and reset.
module tb_video_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] psel = 2'd0;
    logic [1:0] psel2 = 2'd1;
    logic [7:0] sol_r = '0, sol_g = '0, sol_b = '0;
    logic       hs, vs, de, fs, hs2, vs2, de2, fs2;
    logic [7:0] r, g, b, r2, g2, b2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .GRID_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .pattern_sel(psel),
        .solid_r(sol_r), .solid_g(sol_g), .solid_b(sol_b),
        .hs(hs), .vs(vs), .de(de), .rgb_r(r), .rgb_g(g), .rgb_b(b), .frame_start(fs)
    );

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .GRID_LOG2(2),
        .RAMP_SHIFT(0), .HS_POL(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .pattern_sel(psel2),
        .solid_r(8'h00), .solid_g(8'h00), .solid_b(8'h00),
        .hs(hs2), .vs(vs2), .de(de2), .rgb_r(r2), .rgb_g(g2), .rgb_b(b2), .frame_start(fs2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    initial begin
        int de_n, hs_n, vs_n, fs_n, h, v, f, k_end;
        logic e_de, e_hs, e_white;
        logic [7:0]  x8;
        logic [23:0] e_rgb;
        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        repeat (5) tick();
        check("rst_de", de, 0);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_hs", hs, 0);
        check("rst_vs", vs, 0);
        check("rst_fs", fs, 0);
        check("rst_hs_neg", hs2, 1);
        check("rst_vs2", vs2, 0);
        rst = 1'b0;
        k_end = 6 * 242 + 5 * 22 + 7;
        for (int k = 0; k < k_end; k++) begin
            tick();
            h = k % 22;
            v = (k / 22) % 11;
            f = k / 242;
            x8 = 8'(h);
            e_de = (h < 16) && (v < 8);
            e_hs = (h == 18) || (h == 19);
            e_white = (h == 0 || h == 4 || h == 8 || h == 12 || h == 15) ||
                      (v == 0 || v == 4 || v == 7);
            e_rgb = !e_de ? 24'h0 : f <= 3 ? bars[h / 2] : f == 4 ? 24'h123456 :
                    e_white ? 24'hFFFFFF : 24'h000000;
            check("de", de, e_de);
            check("hs", hs, e_hs);
            check("vs", vs, v == 9);
            check("fs", fs, h == 0 && v == 0);
            check("rgb", {r, g, b}, e_rgb);
            if (f >= 1) begin
                check("ramp", {r2, g2, b2}, e_de ? {x8, x8, x8} : 24'h0);
                check("hs_neg", hs2, !e_hs);
            end
            if (f < 3) begin
                de_n += int'(de);
                hs_n += int'(hs);
                vs_n += int'(vs);
                fs_n += int'(fs);
            end
            if (k == 3 * 242 - 1) begin
                check("de_count", de_n, 384);
                check("hs_count", hs_n, 66);
                check("vs_count", vs_n, 66);
                check("fs_count", fs_n, 3);
            end
            if (f == 3 && v == 3 && h == 5) begin
                psel = 2'd3;
                sol_r = 8'h12;
                sol_g = 8'h34;
                sol_b = 8'h56;
            end
            if (f == 4 && v == 3 && h == 5)
                psel = 2'd2;
        end
        rst = 1'b1;
        repeat (3) tick();
        check("mid_rst_de", de, 0);
        check("mid_rst_rgb", {r, g, b}, 0);
        check("mid_rst_hs", hs, 0);
        rst = 1'b0;
        tick();
        check("restart_de", de, 1);
        check("restart_fs", fs, 1);
        check("restart_rgb0", {r, g, b}, 24'hFFFFFF);
        tick();
        check("restart_rgb1", {r, g, b}, 24'hFFFFFF);
        check("restart_fs1", fs, 0);
        tick();
        check("restart_rgb2", {r, g, b}, 24'hFFFF00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
